// File: rtl/btn_updown_counter_pkg.sv
// Shared definitions for the push-button up/down counter.
//   clog2       : constant-function ceiling log2, minimum result 1
//   DEB_CW      : debounce counter width for the default debounce length
//   upd_op_e    : update operation selected from the three press events
//   decode_op   : press events -> update operation, clear has top priority
package btn_updown_counter_pkg;

    localparam int DEB_CYCLES_DEF = 50000;

    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if (value > (1 << i)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int DEB_CW = clog2(DEB_CYCLES_DEF);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_CANCEL,
        OP_UP,
        OP_DN
    } upd_op_e;

    function automatic upd_op_e decode_op(input logic clr, input logic up, input logic dn);
        upd_op_e op;
        if (clr) begin
            op = OP_CLR;
        end else if (up && dn) begin
            op = OP_CANCEL;
        end else if (up) begin
            op = OP_UP;
        end else if (dn) begin
            op = OP_DN;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/btn_updown_counter_debounce.sv
// Synchroniser + debouncer + press detector for one raw active-low button.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   btn_n  in  raw button pin, low = pressed, asynchronous to clk
//   level  out accepted (debounced) button level, 1 = released
//   press  out one-cycle pulse when the accepted level goes 1 -> 0
module btn_debounce_n
    import btn_updown_counter_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = clog2(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] deb_cnt;

    // The counter only runs while the synchronised level disagrees with the
    // accepted one, so any bounce back to the accepted level restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            level   <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                level   <= sync_2;
                deb_cnt <= '0;
                press   <= ~sync_2;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/btn_updown_counter.sv
// Up/down counter driven by three raw active-low push buttons.
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   btn_up_n   in  raw up button, low = pressed
//   btn_dn_n   in  raw down button, low = pressed
//   btn_clr_n  in  raw clear button, low = pressed
//   count      out current counter value
//   led        out count, inverted when LED_ACTIVE_LOW != 0
//   limit      out one-cycle pulse on a wrap or a clamped step
module btn_updown_counter
    import btn_updown_counter_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
    parameter int SATURATE       = 0,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up_n,
    input  logic             btn_dn_n,
    input  logic             btn_clr_n,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] led,
    output logic             limit
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic    press_up;
    logic    press_dn;
    logic    press_clr;
    // Debounced levels are not needed by the count logic; kept for probing.
    logic [2:0] btn_level_unused;
    upd_op_e op;

    btn_debounce_n #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_up_n),
        .level (btn_level_unused[0]),
        .press (press_up)
    );

    btn_debounce_n #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_dn_n),
        .level (btn_level_unused[1]),
        .press (press_dn)
    );

    btn_debounce_n #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_clr_n),
        .level (btn_level_unused[2]),
        .press (press_clr)
    );

    assign op = decode_op(press_clr, press_up, press_dn);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            limit <= 1'b0;
        end else begin
            limit <= 1'b0;
            case (op)
                OP_CLR: begin
                    count <= '0;
                end
                OP_UP: begin
                    if (count == CNT_MAX) begin
                        limit <= 1'b1;
                        count <= (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end
                OP_DN: begin
                    if (count == '0) begin
                        limit <= 1'b1;
                        count <= (SATURATE != 0) ? '0 : CNT_MAX;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    assign led = (LED_ACTIVE_LOW != 0) ? ~count : count;

endmodule

// File: tb/tb_btn_updown_counter.sv
module tb_btn_updown_counter;

    localparam int W    = 2;
    localparam int DEB  = 4;
    localparam int MODV = 1 << W;
    localparam int MAXV = MODV - 1;

    logic clk;
    logic reset;
    logic btn_up_n;
    logic btn_dn_n;
    logic btn_clr_n;
    logic [W-1:0] count_w, led_w, count_s, led_s;
    logic limit_w, limit_s;

    int n_cmp = 0;
    int n_bad = 0;

    // wrapping counter, active-low LEDs
    btn_updown_counter #(.WIDTH(W), .DEB_CYCLES(DEB), .SATURATE(0), .LED_ACTIVE_LOW(1)) dut_wrap (
        .clk(clk), .reset(reset), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .btn_clr_n(btn_clr_n), .count(count_w), .led(led_w), .limit(limit_w)
    );

    // saturating counter, active-high LEDs
    btn_updown_counter #(.WIDTH(W), .DEB_CYCLES(DEB), .SATURATE(1), .LED_ACTIVE_LOW(0)) dut_sat (
        .clk(clk), .reset(reset), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .btn_clr_n(btn_clr_n), .count(count_s), .led(led_s), .limit(limit_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Button b (0 up, 1 dn, 2 clr): the synchronised level seen at an edge is
    // the pin as it stood two edges earlier. The accepted level flips once the
    // last DEB synchronised samples all disagree with it; a flip to 0 is a
    // press, which changes the count on the following edge.
    bit pin_d1[3], pin_d2[3], acc[3], ev[3];
    bit win[3][DEB];
    int m_cnt[2];
    bit m_lim[2];

    function automatic bit pin_now(input int b);
        case (b)
            0:       return btn_up_n;
            1:       return btn_dn_n;
            default: return btn_clr_n;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 3; b++) begin
                pin_d1[b] = 1'b1; pin_d2[b] = 1'b1; acc[b] = 1'b1; ev[b] = 1'b0;
                for (int j = 0; j < DEB; j++) win[b][j] = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_lim[k] = 1'b0; end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int nxt;
                m_lim[k] = 1'b0;
                if (ev[2]) begin
                    m_cnt[k] = 0;
                end else if (ev[0] && !ev[1]) begin
                    nxt = (m_cnt[k] + 1) % MODV;
                    if (nxt == 0) begin
                        m_lim[k] = 1'b1;
                        if (k == 1) nxt = MAXV;
                    end
                    m_cnt[k] = nxt;
                end else if (ev[1] && !ev[0]) begin
                    nxt = (m_cnt[k] + MODV - 1) % MODV;
                    if (nxt == MAXV) begin
                        m_lim[k] = 1'b1;
                        if (k == 1) nxt = 0;
                    end
                    m_cnt[k] = nxt;
                end
            end
            for (int b = 0; b < 3; b++) begin
                bit s, all_diff;
                s = pin_d2[b];
                pin_d2[b] = pin_d1[b];
                pin_d1[b] = pin_now(b);
                for (int j = 0; j < DEB - 1; j++) win[b][j] = win[b][j+1];
                win[b][DEB-1] = s;
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++) if (win[b][j] == acc[b]) all_diff = 1'b0;
                ev[b] = 1'b0;
                if (all_diff) begin
                    acc[b] = s;
                    ev[b] = (s == 1'b0);
                end
            end
        end
    end

    // one compare process, every cycle
    always @(negedge clk) begin
        check("wrap.count", count_w, m_cnt[0]);
        check("wrap.led",   led_w,   MAXV - m_cnt[0]);
        check("wrap.limit", limit_w, m_lim[0]);
        check("sat.count",  count_s, m_cnt[1]);
        check("sat.led",    led_s,   m_cnt[1]);
        check("sat.limit",  limit_s, m_lim[1]);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit [2:0] mask, input bit v);
        if (mask[0]) btn_up_n  = v;
        if (mask[1]) btn_dn_n  = v;
        if (mask[2]) btn_clr_n = v;
    endtask

    // Clean press on the buttons in mask; checks timing of the step literally.
    task automatic press(input string tag, input bit [2:0] mask,
                         input int pw, input int ps, input int nw, input int ns,
                         input bit lw, input bit ls);
        @(negedge clk);
        drive(mask, 1'b0);
        repeat (DEB + 2) @(posedge clk);
        #1;
        check({tag, ".early.w"}, count_w, pw);
        check({tag, ".early.s"}, count_s, ps);
        @(posedge clk);
        #1;
        check({tag, ".w"}, count_w, nw);
        check({tag, ".s"}, count_s, ns);
        check({tag, ".lim.w"}, limit_w, lw);
        check({tag, ".lim.s"}, limit_s, ls);
        @(posedge clk);
        #1;
        check({tag, ".limoff.w"}, limit_w, 1'b0);
        check({tag, ".limoff.s"}, limit_s, 1'b0);
        @(negedge clk);
        drive(mask, 1'b1);
        repeat (DEB + 6) @(negedge clk);
    endtask

    initial begin
        int hold[3];
        reset = 1'b0;
        btn_up_n = 1'b1; btn_dn_n = 1'b1; btn_clr_n = 1'b1;

        // 1. reset
        repeat (3) @(negedge clk);
        #1;
        check("rst.count", count_w, 0);
        check("rst.led_al", led_w, 2'b11);
        check("rst.led_ah", led_s, 2'b00);
        check("rst.limit", limit_w, 1'b0);
        @(negedge clk); #2 reset = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("idle.count", count_w, 0);

        // 2. up wrap / clamp
        press("up1", 3'b001, 0, 0, 1, 1, 0, 0);
        press("up2", 3'b001, 1, 1, 2, 2, 0, 0);
        press("up3", 3'b001, 2, 2, 3, 3, 0, 0);
        press("up4", 3'b001, 3, 3, 0, 3, 1, 1);

        // 3. bounce: 2-cycle levels never accepted, then a solid press
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            btn_up_n = ~btn_up_n;
            repeat (2) @(negedge clk);
        end
        btn_up_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_up_n = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        #1;
        check("bounce.w", count_w, 1);
        check("bounce.s", count_s, 3);

        // 4. down from 0, ups to the top
        press("clr",  3'b100, 1, 3, 0, 0, 0, 0);
        press("dn0",  3'b010, 0, 0, 3, 0, 1, 1);
        press("upA",  3'b001, 3, 0, 0, 1, 1, 0);
        press("upB",  3'b001, 0, 1, 1, 2, 0, 0);
        press("upC",  3'b001, 1, 2, 2, 3, 0, 0);
        press("upD",  3'b001, 2, 3, 3, 3, 0, 1);

        // 5. priority
        press("updn",  3'b011, 3, 3, 3, 3, 0, 0);
        press("clrup", 3'b101, 3, 3, 0, 0, 0, 0);

        // 6. reset mid-debounce, button held through release
        press("r_up1", 3'b001, 0, 0, 1, 1, 0, 0);
        press("r_up2", 3'b001, 1, 1, 2, 2, 0, 0);
        @(negedge clk);
        btn_up_n = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst.w", count_w, 0);
        check("midrst.s", count_s, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (DEB + 2) @(posedge clk);
        #1;
        check("held.early", count_w, 0);
        @(posedge clk);
        #1;
        check("held.w", count_w, 1);
        check("held.s", count_s, 1);
        @(negedge clk);
        btn_up_n = 1'b1;
        repeat (DEB + 6) @(negedge clk);

        // random bouncy presses on all three buttons
        for (int b = 0; b < 3; b++) hold[b] = $urandom_range(1, 14);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (c == 700) begin
                #2 reset = 1'b0;
                #10 reset = 1'b1;
            end
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    drive(3'b001 << b, ~pin_now(b));
                    hold[b] = $urandom_range(1, 14);
                end else begin
                    hold[b]--;
                end
            end
        end
        @(negedge clk);
        drive(3'b111, 1'b1);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
